writeback_arbiter: RTL and testbench
====================================

WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 64, SHALL set the width of the write data.
REQ-002 Parameter ADDR_WIDTH, default 5, SHALL set the width of the register address.
REQ-003 in_Clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 in_Rst_N  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 in_A_valid  input  1  SHALL flag a single-cycle (integer pipe) result offer.
REQ-006 in_A_addr / in_A_data  input  ADDR_WIDTH / DATA_WIDTH  SHALL carry destination and value for source A.
REQ-007 out_A_ready  output  1  SHALL be the combinational acceptance of source A this cycle.
REQ-008 in_B_valid  input  1  SHALL flag a long-latency (load/FPU) result offer.
REQ-009 in_B_addr / in_B_data  input  ADDR_WIDTH / DATA_WIDTH  SHALL carry destination and value for source B.
REQ-010 out_B_ready  output  1  SHALL be the acceptance of source B into the B buffer.
REQ-011 out_write_En  output  1  SHALL be the registered register-file write enable.
REQ-012 out_writeAddr / out_data  output  ADDR_WIDTH / DATA_WIDTH  SHALL be the registered write address and data.

Function
REQ-013 A transfer SHALL occur on a source when its valid and ready are both 1 at a rising edge.
REQ-014 Source B SHALL feed a 2-entry FIFO; out_B_ready SHALL be 1 iff FIFO count < 2, independent of the current pop.
REQ-015 The grant SHALL go to the FIFO head if the FIFO is non-empty and not (in_A_valid and starve_cnt == 2); otherwise to A if in_A_valid; otherwise there is no grant.
REQ-016 out_A_ready SHALL be 1 only in cycles where A holds the grant.
REQ-017 starve_cnt (2 bits) SHALL increment, saturating at 2, when the FIFO is granted while in_A_valid=1, and SHALL clear when A is granted or in_A_valid=0.
REQ-018 A granted entry SHALL appear on out_writeAddr/out_data at the next edge; A latency is 1 cycle, B latency is at least 2 cycles (push, then pop).
REQ-019 out_write_En SHALL be 1 for exactly one cycle per granted entry whose address is non-zero.
REQ-020 A granted entry addressed to register 0 SHALL complete its handshake and pop, with out_write_En=0.
REQ-021 When there is no grant, out_write_En SHALL be 0 and out_writeAddr/out_data SHALL hold their previous values.
REQ-022 A simultaneous push and pop with count==2 SHALL be impossible because out_B_ready=0; at count==1, push and pop SHALL leave count at 1 and preserve order.
REQ-023 The FIFO SHALL preserve B arrival order; pointers SHALL wrap modulo 2.
REQ-024 The design SHALL never drop or duplicate an accepted entry.

Reset
REQ-025 While in_Rst_N=0, FIFO count, pointers and starve_cnt SHALL be 0, and out_write_En, out_writeAddr and out_data SHALL be 0.
REQ-026 Assertion mid-operation SHALL discard buffered B entries immediately, asynchronously to in_Clk.
REQ-027 Immediately after reset, out_B_ready=1 and out_A_ready SHALL follow in_A_valid.

Verification
REQ-028 A only: A valid with addr 3, data 0x11, one cycle -> next cycle out_write_En=1, addr 3, data 0x11; then out_write_En=0.
REQ-029 B only: B pushes addr 5/0xAA then addr 6/0xBB back-to-back -> writes 5/0xAA then 6/0xBB on consecutive cycles, starting 2 cycles after the first push.
REQ-030 Full: hold B valid for 3 cycles while A is continuously valid -> out_B_ready=0 once count reaches 2; no entry is lost.
REQ-031 Starvation: FIFO kept non-empty and A held valid (addr 7) -> the FIFO wins 2 grants, A wins the 3rd, and the pattern repeats.
REQ-032 x0: A with addr 0, data 0xFF -> out_A_ready=1, and out_write_En stays 0 the following cycle.
REQ-033 Reset mid-run: 2 B entries buffered, pulse in_Rst_N low -> all outputs 0, out_B_ready=1, and no stale write after release.

Source files
------------

// File: rtl/writeback_arbiter.sv
// Write-back arbiter: merges a single-cycle source A and a 2-entry buffered source B
// into one registered register-file write port, with an anti-starvation rule for A.
module writeback_arbiter #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  in_Clk,
  input  logic                  in_Rst_N,
  input  logic                  in_A_valid,
  input  logic [ADDR_WIDTH-1:0] in_A_addr,
  input  logic [DATA_WIDTH-1:0] in_A_data,
  output logic                  out_A_ready,
  input  logic                  in_B_valid,
  input  logic [ADDR_WIDTH-1:0] in_B_addr,
  input  logic [DATA_WIDTH-1:0] in_B_data,
  output logic                  out_B_ready,
  output logic                  out_write_En,
  output logic [ADDR_WIDTH-1:0] out_writeAddr,
  output logic [DATA_WIDTH-1:0] out_data
);

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_A,
    GNT_B
  } grant_e;

  logic [ADDR_WIDTH-1:0] fifo_addr_q [2];
  logic [DATA_WIDTH-1:0] fifo_data_q [2];
  logic                  wr_ptr_q, wr_ptr_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic [1:0]            count_q, count_d;
  logic [1:0]            starve_q, starve_d;

  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

  grant_e                grant;
  logic                  push, pop;
  logic                  fifo_nonempty;

  assign fifo_nonempty = (count_q != 2'd0);
  // Readiness depends only on the stored count, never on this cycle's pop.
  assign out_B_ready   = (count_q < 2'd2);
  assign push          = in_B_valid && out_B_ready;

  // NOTE: every signal driven here gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    grant    = GNT_NONE;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    starve_d = 2'd0;
    we_d     = 1'b0;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;

    if (fifo_nonempty && !(in_A_valid && starve_q == 2'd2)) begin
      grant = GNT_B;
    end else if (in_A_valid) begin
      grant = GNT_A;
    end

    if (grant == GNT_B && in_A_valid) begin
      starve_d = (starve_q == 2'd2) ? 2'd2 : starve_q + 2'd1;
    end

    unique case (grant)
      GNT_A: begin
        waddr_d = in_A_addr;
        wdata_d = in_A_data;
        we_d    = (in_A_addr != '0);
      end
      GNT_B: begin
        waddr_d = fifo_addr_q[rd_ptr_q];
        wdata_d = fifo_data_q[rd_ptr_q];
        we_d    = (fifo_addr_q[rd_ptr_q] != '0);
      end
      default: ;
    endcase

    if (push) wr_ptr_d = ~wr_ptr_q;
    if (pop)  rd_ptr_d = ~rd_ptr_q;

    unique case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  assign pop         = (grant == GNT_B);
  assign out_A_ready = (grant == GNT_A);

  // NOTE: control state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge in_Clk or negedge in_Rst_N) begin
    if (!in_Rst_N) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      starve_q <= 2'd0;
      we_q     <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      starve_q <= starve_d;
      we_q     <= we_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
    end
  end

  // NOTE: the FIFO storage is not reset; count and pointers alone define which entries are live.
  always_ff @(posedge in_Clk) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q] <= in_B_addr;
      fifo_data_q[wr_ptr_q] <= in_B_data;
    end
  end

  assign out_write_En  = we_q;
  assign out_writeAddr = waddr_q;
  assign out_data      = wdata_q;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed self-checking bench for writeback_arbiter: A-only, B-only, full FIFO with
// starvation rotation, register-0 entries and asynchronous reset mid-run.
module tb_writeback_arbiter;

  localparam int DW = 64;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          a_valid;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_data;
  logic          a_ready;
  logic          b_valid;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_data;
  logic          b_ready;
  logic          we;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;

  int n_checks = 0;
  int n_errors = 0;

  writeback_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .in_Clk        (clk),
    .in_Rst_N      (rst_n),
    .in_A_valid    (a_valid),
    .in_A_addr     (a_addr),
    .in_A_data     (a_data),
    .out_A_ready   (a_ready),
    .in_B_valid    (b_valid),
    .in_B_addr     (b_addr),
    .in_B_data     (b_data),
    .out_B_ready   (b_ready),
    .out_write_En  (we),
    .out_writeAddr (waddr),
    .out_data      (wdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic v, input logic [AW-1:0] ad, input logic [DW-1:0] d);
    a_valid = v;
    a_addr  = ad;
    a_data  = d;
    #1;
  endtask

  task automatic drive_b(input logic v, input logic [AW-1:0] ad, input logic [DW-1:0] d);
    b_valid = v;
    b_addr  = ad;
    b_data  = d;
    #1;
  endtask

  task automatic check_wr(input string tag, input logic e, input logic [AW-1:0] ad,
                          input logic [DW-1:0] d);
    check({tag, ".we"}, DW'(we), DW'(e));
    check({tag, ".addr"}, DW'(waddr), DW'(ad));
    check({tag, ".data"}, wdata, d);
  endtask

  initial begin
    rst_n = 1'b0;
    drive_a(1'b0, '0, '0);
    drive_b(1'b0, '0, '0);
    step();
    step();

    // Reset state
    check_wr("rst", 1'b0, 5'd0, 64'h0);
    check("rst.b_ready", DW'(b_ready), 64'd1);
    check("rst.a_ready", DW'(a_ready), 64'd0);
    rst_n = 1'b1;
    step();

    // A only: addr 3 / 0x11
    drive_a(1'b1, 5'd3, 64'h11);
    check("a_only.a_ready", DW'(a_ready), 64'd1);
    step();
    drive_a(1'b0, '0, '0);
    check_wr("a_only.w", 1'b1, 5'd3, 64'h11);
    check("a_only.a_ready_idle", DW'(a_ready), 64'd0);
    step();
    check_wr("a_only.hold", 1'b0, 5'd3, 64'h11);

    // B only: 5/0xAA then 6/0xBB back-to-back
    drive_b(1'b1, 5'd5, 64'hAA);
    check("b_only.b_ready0", DW'(b_ready), 64'd1);
    step();
    drive_b(1'b1, 5'd6, 64'hBB);
    check("b_only.no_wr_yet", DW'(we), 64'd0);
    check("b_only.b_ready1", DW'(b_ready), 64'd1);
    step();
    drive_b(1'b0, '0, '0);
    check_wr("b_only.w0", 1'b1, 5'd5, 64'hAA);
    step();
    check_wr("b_only.w1", 1'b1, 5'd6, 64'hBB);
    step();
    check_wr("b_only.idle", 1'b0, 5'd6, 64'hBB);

    // Full FIFO plus starvation rotation: A held valid at 7/0x77, B offers a stream
    drive_a(1'b1, 5'd7, 64'h77);
    drive_b(1'b1, 5'd10, 64'hB0);
    check("full.c0.a_ready", DW'(a_ready), 64'd1);
    step();
    check_wr("full.e1", 1'b1, 5'd7, 64'h77);
    drive_b(1'b1, 5'd11, 64'hB1);
    check("full.c1.a_ready", DW'(a_ready), 64'd0);
    step();
    check_wr("full.e2", 1'b1, 5'd10, 64'hB0);
    drive_b(1'b1, 5'd12, 64'hB2);
    check("full.c2.a_ready", DW'(a_ready), 64'd0);
    step();
    check_wr("full.e3", 1'b1, 5'd11, 64'hB1);
    drive_b(1'b1, 5'd13, 64'hB3);
    check("full.c3.a_ready", DW'(a_ready), 64'd1);
    check("full.c3.b_ready", DW'(b_ready), 64'd1);
    step();
    check_wr("full.e4", 1'b1, 5'd7, 64'h77);
    drive_b(1'b1, 5'd14, 64'hB4);
    check("full.c4.b_ready", DW'(b_ready), 64'd0);
    check("full.c4.a_ready", DW'(a_ready), 64'd0);
    step();
    check_wr("full.e5", 1'b1, 5'd12, 64'hB2);
    check("full.c5.b_ready", DW'(b_ready), 64'd1);
    step();
    check_wr("full.e6", 1'b1, 5'd13, 64'hB3);
    drive_b(1'b0, '0, '0);
    check("full.c6.a_ready", DW'(a_ready), 64'd1);
    step();
    check_wr("full.e7", 1'b1, 5'd7, 64'h77);
    check("full.c7.a_ready", DW'(a_ready), 64'd0);
    step();
    check_wr("full.e8", 1'b1, 5'd14, 64'hB4);
    drive_a(1'b0, '0, '0);
    check("full.c8.a_ready", DW'(a_ready), 64'd0);
    step();
    check_wr("full.e9", 1'b0, 5'd14, 64'hB4);

    // Register 0: A then B entries complete without a write enable
    drive_a(1'b1, 5'd0, 64'hFF);
    check("x0.a_ready", DW'(a_ready), 64'd1);
    step();
    drive_a(1'b0, '0, '0);
    check_wr("x0.a", 1'b0, 5'd0, 64'hFF);
    drive_b(1'b1, 5'd0, 64'h5);
    step();
    drive_b(1'b0, '0, '0);
    check("x0.b_pushed", DW'(we), 64'd0);
    step();
    check_wr("x0.b_pop", 1'b0, 5'd0, 64'h5);
    check("x0.b_ready", DW'(b_ready), 64'd1);
    step();
    check_wr("x0.no_dup", 1'b0, 5'd0, 64'h5);

    // Reset mid-run with two B entries buffered
    drive_a(1'b1, 5'd2, 64'h22);
    drive_b(1'b1, 5'd20, 64'hC0);
    step();
    drive_b(1'b1, 5'd21, 64'hC1);
    step();
    drive_b(1'b1, 5'd22, 64'hC2);
    step();
    drive_b(1'b1, 5'd23, 64'hC3);
    check("rr.c3.a_ready", DW'(a_ready), 64'd1);
    step();
    drive_b(1'b0, '0, '0);
    drive_a(1'b0, '0, '0);
    check_wr("rr.e4", 1'b1, 5'd2, 64'h22);
    check("rr.full.b_ready", DW'(b_ready), 64'd0);
    rst_n = 1'b0;
    #1;
    check_wr("rr.async", 1'b0, 5'd0, 64'h0);
    check("rr.async.b_ready", DW'(b_ready), 64'd1);
    check("rr.async.a_ready", DW'(a_ready), 64'd0);
    step();
    rst_n = 1'b1;
    drive_a(1'b1, 5'd4, 64'h44);
    check("rr.post.a_ready", DW'(a_ready), 64'd1);
    drive_a(1'b0, '0, '0);
    check("rr.post.a_ready_off", DW'(a_ready), 64'd0);
    step();
    check_wr("rr.stale0", 1'b0, 5'd0, 64'h0);
    step();
    check_wr("rr.stale1", 1'b0, 5'd0, 64'h0);
    check("rr.post.b_ready", DW'(b_ready), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
